// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round functions and FSM state type.
// This package is used by sha256_round and sha256_round_engine.
package sha256_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [WORD_W-1:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [8*WORD_W-1:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] e,
                                             input logic [WORD_W-1:0] f,
                                             input logic [WORD_W-1:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] a,
                                              input logic [WORD_W-1:0] b,
                                              input logic [WORD_W-1:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// Combinational SHA-256 round and message-schedule step.
// The top module chains ROUNDS_PER_CYCLE copies of this block for each clock.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [8*WORD_W-1:0]  st_i,
    input  logic [16*WORD_W-1:0] win_i,
    input  logic [WORD_W-1:0]    k_i,
    output logic [8*WORD_W-1:0]  st_o,
    output logic [16*WORD_W-1:0] win_o
);

    logic [WORD_W-1:0] a, b, c, d, e, f, g, h;
    logic [WORD_W-1:0] w0, w1, w9, w14, w_new, t1, t2;

    assign {a, b, c, d, e, f, g, h} = st_i;

    // Window word 0 is W[t]. Word j holds W[t+j].
    assign w0  = win_i[16*WORD_W-1  -: WORD_W];
    assign w1  = win_i[15*WORD_W-1  -: WORD_W];
    assign w9  = win_i[7*WORD_W-1   -: WORD_W];
    assign w14 = win_i[2*WORD_W-1   -: WORD_W];

    assign w_new = small_sigma1(w14) + w9 + small_sigma0(w1) + w0;
    assign t1    = h + big_sigma1(e) + ch(e, f, g) + k_i + w0;
    assign t2    = big_sigma0(a) + maj(a, b, c);

    assign st_o  = {t1 + t2, a, b, c, d + t1, e, f, g};
    assign win_o = {win_i[15*WORD_W-1:0], w_new};

endmodule

// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression core running ROUNDS_PER_CYCLE rounds per clock, with feed-forward.
// Define SHA256_TARGET_CMP_EN to add the target input and the registered digest <= target hit output.
module sha256_round_engine
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic [255:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_digest,
    output logic         busy
`ifdef SHA256_TARGET_CMP_EN
    ,
    input  logic [255:0] target,
    output logic         hit
`endif
);

    localparam int R = ROUNDS_PER_CYCLE;

    if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_r
        $error("sha256_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_e         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [255:0]   work_q, work_d;
    logic [511:0]   win_q, win_d;
    logic [255:0]   hsave_q, hsave_d;
    logic [255:0]   digest_q, digest_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;
    logic           busy_q, busy_d;
    logic [255:0]   ff_sum;

    logic [255:0]   st_c  [R+1];
    logic [511:0]   win_c [R+1];

    assign st_c[0]  = work_q;
    assign win_c[0] = win_q;

    for (genvar i = 0; i < R; i++) begin : g_round
        sha256_round u_round (
            .st_i  (st_c[i]),
            .win_i (win_c[i]),
            .k_i   (K[cnt_q + 6'(i)]),
            .st_o  (st_c[i+1]),
            .win_o (win_c[i+1])
        );
    end

    always_comb begin
        ff_sum = '0;
        for (int j = 0; j < 8; j++) begin
            ff_sum[j*WORD_W +: WORD_W] = hsave_q[j*WORD_W +: WORD_W] + work_q[j*WORD_W +: WORD_W];
        end
    end

`ifdef SHA256_TARGET_CMP_EN
    logic hit_q, hit_d;
    assign hit = hit_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        win_d       = win_q;
        hsave_d     = hsave_q;
        digest_d    = digest_q;
        out_valid_d = out_valid_q;
`ifdef SHA256_TARGET_CMP_EN
        hit_d       = hit_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    hsave_d = in_state;
                    work_d  = in_state;
                    win_d   = in_block;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                work_d = st_c[R];
                win_d  = win_c[R];
                // The final step lands on 64, which wraps the counter back to 0.
                cnt_d  = cnt_q + 6'(R);
                if (cnt_q == 6'(64 - R)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!out_valid_q) begin
                    digest_d    = ff_sum;
                    out_valid_d = 1'b1;
`ifdef SHA256_TARGET_CMP_EN
                    hit_d       = (ff_sum <= target);
`endif
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            win_q       <= '0;
            hsave_q     <= '0;
            digest_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SHA256_TARGET_CMP_EN
            hit_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            win_q       <= win_d;
            hsave_q     <= hsave_d;
            digest_q    <= digest_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
`ifdef SHA256_TARGET_CMP_EN
            hit_q       <= hit_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_digest = digest_q;
    assign busy       = busy_q;

endmodule
